// File: rtl/p_mac_accum.sv
// Streaming signed multiply-accumulate: NUM (x, w) pairs per frame in, one
// saturated weighted sum per frame out, valid/ready on both sides.

package p_mac_pkg;
    typedef enum logic [1:0] {
        DT_BOOL = 2'd0,
        DT_INT  = 2'd1,
        DT_FXP  = 2'd2,
        DT_FP   = 2'd3
    } dtype_e;

    typedef struct packed {
        dtype_e     dtype;
        logic [7:0] prec;
    } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: p_mac_pkg::DT_INT, prec: 8'd16}
`endif

module p_mac_accum #(
    parameter int               NUM      = 4,
    parameter p_mac_pkg::dconf_t I_CONF  = `DEF_DCONF,
    parameter p_mac_pkg::dconf_t W_CONF  = `DEF_DCONF,
    parameter p_mac_pkg::dconf_t O_CONF  = `DEF_DCONF,
    parameter int               ACC_PREC = int'(I_CONF.prec) + int'(W_CONF.prec) + $clog2(NUM)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [int'(I_CONF.prec)-1:0]     in_x,
    input  logic [int'(W_CONF.prec)-1:0]     in_w,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [int'(O_CONF.prec)-1:0]     out,
    output logic                             ovf
);
    localparam int I_PREC = int'(I_CONF.prec);
    localparam int W_PREC = int'(W_CONF.prec);
    localparam int O_PREC = int'(O_CONF.prec);
    localparam int CNT_W  = $clog2(NUM + 1);

    // INT and FXP share raw two's-complement arithmetic; other formats stall.
    localparam bit I_OK      = (I_CONF.dtype == p_mac_pkg::DT_INT) || (I_CONF.dtype == p_mac_pkg::DT_FXP);
    localparam bit W_OK      = (W_CONF.dtype == p_mac_pkg::DT_INT) || (W_CONF.dtype == p_mac_pkg::DT_FXP);
    localparam bit O_OK      = (O_CONF.dtype == p_mac_pkg::DT_INT) || (O_CONF.dtype == p_mac_pkg::DT_FXP);
    localparam bit SUPPORTED = I_OK && W_OK && O_OK;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [ACC_PREC-1:0] SAT_MAX =
        {{(ACC_PREC - O_PREC + 1){1'b0}}, {(O_PREC - 1){1'b1}}};
    localparam logic signed [ACC_PREC-1:0] SAT_MIN =
        {{(ACC_PREC - O_PREC + 1){1'b1}}, {(O_PREC - 1){1'b0}}};

    logic [1:0]                 state_reg;
    logic [CNT_W-1:0]           cnt_reg;
    logic signed [ACC_PREC-1:0] acc_reg;
    logic                       out_valid_reg;
    logic [O_PREC-1:0]          out_reg;
    logic                       ovf_reg;

    logic                       accept;
    logic                       xfer;
    logic                       last_pair;
    logic signed [ACC_PREC-1:0] x_ext;
    logic signed [ACC_PREC-1:0] w_ext;
    logic signed [ACC_PREC-1:0] prod;
    logic signed [ACC_PREC-1:0] sum_next;
    logic [O_PREC-1:0]          out_next;
    logic                       ovf_next;

    generate
        if (SUPPORTED) begin : g_ready
            assign in_ready = !out_valid_reg || out_ready;
        end else begin : g_stall
            assign in_ready = 1'b0;
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid_reg && out_ready;
    assign last_pair = (state_reg == ST_ACC) && (cnt_reg == CNT_W'(NUM - 1));

    // Both operands widened to the accumulator width; the low ACC_PREC bits
    // of the product equal the exact I+W bit product, sign-extended.
    assign x_ext = ACC_PREC'($signed(in_x));
    assign w_ext = ACC_PREC'($signed(in_w));
    assign prod  = x_ext * w_ext;

    // The first pair of a frame loads rather than adds, including the pair
    // accepted in the same cycle the previous sum transfers out.
    assign sum_next = ((state_reg == ST_ACC) ? acc_reg : '0) + prod;

    always_comb begin
        out_next = sum_next[O_PREC-1:0];
        ovf_next = 1'b0;
        if (sum_next > SAT_MAX) begin
            out_next = SAT_MAX[O_PREC-1:0];
            ovf_next = 1'b1;
        end else if (sum_next < SAT_MIN) begin
            out_next = SAT_MIN[O_PREC-1:0];
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        acc_reg   <= sum_next;
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (last_pair) begin
                            out_reg       <= out_next;
                            ovf_reg       <= ovf_next;
                            out_valid_reg <= 1'b1;
                            acc_reg       <= '0;
                            cnt_reg       <= '0;
                            state_reg     <= ST_DONE;
                        end else begin
                            acc_reg <= sum_next;
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (xfer) begin
                        out_valid_reg <= 1'b0;
                        if (accept) begin
                            acc_reg   <= sum_next;
                            cnt_reg   <= CNT_W'(1);
                            state_reg <= ST_ACC;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    acc_reg       <= '0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_p_mac_accum.sv
// Directed bench for p_mac_accum: 8-bit x/w, 16-bit saturated sum, NUM=4.

module tb_p_mac_accum;
    localparam p_mac_pkg::dconf_t C8  = '{dtype: p_mac_pkg::DT_INT, prec: 8'd8};
    localparam p_mac_pkg::dconf_t C16 = '{dtype: p_mac_pkg::DT_INT, prec: 8'd16};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    p_mac_accum #(
        .NUM    (4),
        .I_CONF (C8),
        .W_CONF (C8),
        .O_CONF (C16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair, confirm the stage is ready, and let it be accepted.
    task automatic push(input int x, input int w);
        in_x     = 8'(x);
        in_w     = 8'(w);
        in_valid = 1'b1;
        #1;
        check("push_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset released");

        // Basic sum
        push(1, 1); push(2, 1); push(3, 1);
        check("basic_no_early_valid", 32'(out_valid), 32'd0);
        push(4, 1);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_out", 32'(out), 32'h000A);
        check("basic_ovf", 32'(ovf), 32'd0);
        $display("basic frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();
        check("basic_drained", 32'(out_valid), 32'd0);

        // Mixed signs
        push(-5, 3); push(7, -2); push(-3, -4); push(2, 6);
        check("signs_out", 32'(out), 32'hFFFB);
        check("signs_ovf", 32'(ovf), 32'd0);
        $display("signs frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();

        // Positive then negative saturation, then a clean frame
        for (int i = 0; i < 4; i++) push(-128, -128);
        check("satpos_out", 32'(out), 32'h7FFF);
        check("satpos_ovf", 32'(ovf), 32'd1);
        $display("sat+ frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();
        for (int i = 0; i < 4; i++) push(127, -128);
        check("satneg_out", 32'(out), 32'h8000);
        check("satneg_ovf", 32'(ovf), 32'd1);
        $display("sat- frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();
        for (int i = 0; i < 4; i++) push(0, 0);
        check("zero_out", 32'(out), 32'h0000);
        check("zero_ovf", 32'(ovf), 32'd0);
        $display("zero frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();

        // Backpressure: offered pairs during the stall must not be taken
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(5, 5);
        in_x     = 8'd50;
        in_w     = 8'd50;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_out", 32'(out), 32'h0064);
            check("bp_ovf", 32'(ovf), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_single_xfer", 32'(out_valid), 32'd0);
        $display("backpressure frame: out held at 100 for 5 cycles");
        for (int i = 0; i < 4; i++) push(1, 1);
        check("bp_next_out", 32'(out), 32'h0004);
        tick();

        // Continuous streaming: first pair of each frame overlaps the transfer
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                case (f)
                    0:       push(1, 1);
                    1:       push(2, 2);
                    default: push(-1, 1);
                endcase
                if (k == 0 && f > 0) check("stream_xfer_clear", 32'(out_valid), 32'd0);
            end
            check("stream_valid", 32'(out_valid), 32'd1);
            case (f)
                0:       check("stream_out0", 32'(out), 32'h0004);
                1:       check("stream_out1", 32'(out), 32'h0010);
                default: check("stream_out2", 32'(out), 32'hFFFC);
            endcase
            $display("stream frame %0d: out=%0d", f, $signed(out));
        end
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Reset mid-frame discards the partial sum
        push(10, 10); push(10, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) push(1, 1);
        check("midrst_out", 32'(out), 32'h0004);
        check("midrst_ovf", 32'(ovf), 32'd0);
        $display("post-reset frame: out=%0d ovf=%0b", $signed(out), ovf);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
